polyphase_mac_engine: RTL and testbench

Self-sequencing polyphase interpolation MAC engine. It succeeds the dual-lane MAC used in the FIR lowpass interpolator. It accepts one input sample per handshake and stores it in an internal circular sample RAM. It then produces PHASES filtered output samples, one per polyphase branch, each a TAPS-term dot product against an external synchronous coefficient ROM. All addressing, accumulation control, buffer clearing and output handshaking are internal.

---
 rtl/polyphase_mac_engine.sv | 200 ++++++++++++++++++++
 tb/tb_polyphase_mac_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_mac_engine.sv
// rtl/polyphase_mac_engine.sv - self-sequencing polyphase interpolation MAC engine
//
// Each input sample is stored in a circular sample RAM. The engine then produces
// PHASES outputs, one per polyphase branch. Each output is a TAPS-term dot product
// against an external ROM with a 1-cycle registered read.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset (restarts buffer clear)
//   din/in_valid/in_ready  input sample handshake (ready only in IDLE)
//   coeff_addr/coeff_data  coefficient ROM port, address = p*TAPS + k
//   dout/out_phase         filtered output and its branch index
//   out_valid/out_ready    output handshake; dout/out_phase held until accepted
//   busy                   engine not in IDLE
//
// Build option: define POLYPHASE_MAC_SAT_EN to clamp dout to the OUT_SIZE range.
// Without it, dout is a wrapping truncation to the low OUT_SIZE bits.
module polyphase_mac_engine #(
  parameter int TAPS        = 8,
  parameter int PHASES      = 2,
  parameter int SAMPLE_SIZE = 16,
  parameter int COEFF_SIZE  = 16,
  parameter int ACC_SIZE    = 40,
  parameter int SHIFT       = 3,
  parameter int OUT_SHIFT   = 0,
  parameter int OUT_SIZE    = 16,
  localparam int AW  = $clog2(TAPS),
  localparam int CAW = $clog2(TAPS * PHASES),
  localparam int PW  = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SAMPLE_SIZE-1:0] din,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [CAW-1:0]         coeff_addr,
  input  logic [COEFF_SIZE-1:0]  coeff_data,
  output logic [OUT_SIZE-1:0]    dout,
  output logic [PW-1:0]          out_phase,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int KW  = $clog2(TAPS + 1);
  localparam int PRW = SAMPLE_SIZE + COEFF_SIZE;
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
  localparam logic [KW-1:0] K_END  = KW'(TAPS);
  localparam logic [AW-1:0] W_LAST = AW'(TAPS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PHASES - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_MAC, S_OUT} state_t;

  state_t                      state_q, state_d;
  logic [AW-1:0]               wp_q, wp_d;
  logic [AW-1:0]               n_q, n_d;
  // Shared counter: clear address in CLEAR, tap index in MAC (TAPS = drain cycle).
  logic [KW-1:0]               k_q, k_d;
  logic [PW-1:0]               p_q, p_d;
  logic signed [ACC_SIZE-1:0]  acc_q, acc_d;
  // Read-issue tags, delayed one cycle so they line up with RAM/ROM data.
  logic                        rd_vld_q, rd_vld_d;
  logic                        rd_first_q, rd_first_d;

  logic [SAMPLE_SIZE-1:0]      ram [TAPS];
  logic signed [SAMPLE_SIZE-1:0] x_q;
  logic                        we;
  logic [AW-1:0]               waddr;
  logic [SAMPLE_SIZE-1:0]      wdata;
  logic [AW-1:0]               ra;
  logic [AW:0]                 n_ext, k_ext, ra_ext;

  logic signed [PRW-1:0]       prod, psh;
  logic signed [ACC_SIZE-1:0]  term;
  logic signed [ACC_SIZE-1:0]  acc_sh;

  // Sample address (n-k) mod TAPS, valid for non-power-of-two TAPS as well.
  assign n_ext  = {1'b0, n_q};
  assign k_ext  = (AW + 1)'(k_q);
  assign ra_ext = (n_ext >= k_ext) ? (n_ext - k_ext) : (n_ext + (AW + 1)'(TAPS) - k_ext);
  assign ra     = AW'(ra_ext);

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
    x_q <= ram[ra];
  end

  assign prod = x_q * $signed(coeff_data);
  assign psh  = prod >>> SHIFT;
  assign term = {{(ACC_SIZE - PRW){psh[PRW-1]}}, psh};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      wp_q       <= '0;
      n_q        <= '0;
      k_q        <= '0;
      p_q        <= '0;
      acc_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      n_q        <= n_d;
      k_q        <= k_d;
      p_q        <= p_d;
      acc_q      <= acc_d;
      rd_vld_q   <= rd_vld_d;
      rd_first_q <= rd_first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    n_d        = n_q;
    k_d        = k_q;
    p_d        = p_q;
    acc_d      = acc_q;
    rd_vld_d   = 1'b0;
    rd_first_d = 1'b0;
    we         = 1'b0;
    waddr      = wp_q;
    wdata      = din;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    coeff_addr = '0;

    if (rd_vld_q) acc_d = rd_first_q ? term : (acc_q + term);

    case (state_q)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = AW'(k_q);
        wdata = '0;
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          we      = 1'b1;
          n_d     = wp_q;
          wp_d    = (wp_q == W_LAST) ? '0 : wp_q + 1'b1;
          p_d     = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        // The cycle after the last read only lets the final product land.
        if (k_q == K_END) begin
          state_d = S_OUT;
        end else begin
          coeff_addr = CAW'(p_q) * CAW'(TAPS) + CAW'(k_q);
          rd_vld_d   = 1'b1;
          rd_first_d = (k_q == '0);
          k_d        = k_q + 1'b1;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          k_d = '0;
          if (p_q == P_LAST) begin
            state_d = S_IDLE;
          end else begin
            p_d     = p_q + 1'b1;
            state_d = S_MAC;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  assign acc_sh    = acc_q >>> OUT_SHIFT;
  assign out_phase = p_q;

`ifdef POLYPHASE_MAC_SAT_EN
  localparam logic signed [ACC_SIZE-1:0] SAT_MAX =
    {{(ACC_SIZE - OUT_SIZE + 1){1'b0}}, {(OUT_SIZE - 1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] SAT_MIN =
    {{(ACC_SIZE - OUT_SIZE + 1){1'b1}}, {(OUT_SIZE - 1){1'b0}}};

  always_comb begin
    dout = OUT_SIZE'(acc_sh);
    if (acc_sh > SAT_MAX) dout = OUT_SIZE'(SAT_MAX);
    else if (acc_sh < SAT_MIN) dout = OUT_SIZE'(SAT_MIN);
  end
`else
  assign dout = OUT_SIZE'(acc_sh);
`endif

endmodule

// File: tb/tb_polyphase_mac_engine.sv
// tb/tb_polyphase_mac_engine.sv - table-driven scoreboard bench for polyphase_mac_engine
module tb_polyphase_mac_engine;

  localparam int TAPS   = 4;
  localparam int PHASES = 2;
  localparam int LAT    = TAPS + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  coeff_addr;
  logic [15:0] coeff_data = '0;
  logic [15:0] dout;
  logic [0:0]  out_phase;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  logic [15:0] rom [TAPS*PHASES];

  polyphase_mac_engine #(
    .TAPS(TAPS), .PHASES(PHASES), .SAMPLE_SIZE(16), .COEFF_SIZE(16),
    .ACC_SIZE(40), .SHIFT(3), .OUT_SHIFT(0), .OUT_SIZE(16)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .coeff_addr(coeff_addr), .coeff_data(coeff_data), .dout(dout),
    .out_phase(out_phase), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) coeff_data <= rom[coeff_addr];

  typedef struct {
    bit          do_rst;
    int          rom_mode;
    logic [15:0] dv;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        ph;
  } exp_t;

`ifdef POLYPHASE_MAC_SAT_EN
  localparam logic [15:0] S1 = 16'h7FFF, S2 = 16'h7FFF, S3 = 16'h7FFF, S4 = 16'h7FFF;
`else
  localparam logic [15:0] S1 = 16'hE000, S2 = 16'hC000, S3 = 16'hA000, S4 = 16'h8000;
`endif

  vec_t vecs [11];
  exp_t sb [$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_rom(input int mode);
    for (int i = 0; i < TAPS*PHASES; i++)
      rom[i] = (mode == 0) ? 16'(i + 1) : (mode == 1) ? 16'd3 : 16'h7FFF;
  endtask

  task automatic push_exp(input logic [15:0] d0, input logic [15:0] d1);
    exp_t e;
    e.d = d0; e.ph = 1'b0; sb.push_back(e);
    e.d = d1; e.ph = 1'b1; sb.push_back(e);
  endtask

  // Called at the negedge of the first CLEAR cycle.
  task automatic wait_clear();
    int n = 0;
    bit bad = 0;
    while (!in_ready && n < 50) begin
      if (!busy || out_valid) bad = 1;
      n++;
      @(negedge clk);
    end
    chk("clear_cycles", n, TAPS);
    chk("clear_flags", bad, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_clear();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
  endtask

  // Counts negedges from the current one until out_valid, then scores the output.
  task automatic expect_out(input string nm);
    int j = 0;
    exp_t e;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      j++;
    end while (!out_valid && j < 100);
    chk({nm, "_latency"}, j, LAT);
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_dout"}, dout, e.d);
      chk({nm, "_phase"}, out_phase, e.ph);
    end
  endtask

  task automatic send(input logic [15:0] dv, input string nm);
    wait_ready();
    din = dv;
    in_valid = 1'b1;
    for (int p = 0; p < PHASES; p++) expect_out(nm);
  endtask

  initial begin
    vecs[0]  = '{1, 0, 16'd8,    16'd1,    16'd5};
    vecs[1]  = '{0, 0, 16'd0,    16'd2,    16'd6};
    vecs[2]  = '{0, 0, 16'd0,    16'd3,    16'd7};
    vecs[3]  = '{0, 0, 16'd0,    16'd4,    16'd8};
    vecs[4]  = '{0, 0, 16'd0,    16'd0,    16'd0};
    vecs[5]  = '{1, 1, 16'hFFF8, 16'hFFFD, 16'hFFFD};
    vecs[6]  = '{0, 1, 16'hFFF8, 16'hFFFA, 16'hFFFA};
    vecs[7]  = '{1, 2, 16'h7FFF, S1,       S1};
    vecs[8]  = '{0, 2, 16'h7FFF, S2,       S2};
    vecs[9]  = '{0, 2, 16'h7FFF, S3,       S3};
    vecs[10] = '{0, 2, 16'h7FFF, S4,       S4};
    set_rom(0);

    // Reset state while rst is held.
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_phase", out_phase, 0);
    chk("rst_busy", busy, 1);
    chk("rst_coeff_addr", coeff_addr, 0);
    rst = 1'b0;
    wait_clear();

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_rst) do_reset();
      set_rom(vecs[i].rom_mode);
      push_exp(vecs[i].e0, vecs[i].e1);
      send(vecs[i].dv, $sformatf("vec%0d", i));
    end

    // Backpressure: hold phase 0 for 10 cycles while offering a sample.
    do_reset();
    set_rom(0);
    push_exp(16'd1, 16'd5);
    wait_ready();
    din = 16'd8;
    in_valid = 1'b1;
    out_ready = 1'b0;
    expect_out("bp0");
    begin
      bit bad = 0;
      in_valid = 1'b1;
      din = 16'h1234;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (!out_valid || dout != 16'd1 || out_phase != 1'b0 || in_ready) bad = 1;
      end
      chk("bp_hold_stable", bad, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    expect_out("bp1");
    push_exp(16'd2, 16'd6);
    send(16'd0, "bp_next");

    // Reset in the middle of a MAC: the aborted output never appears and old samples are gone.
    do_reset();
    set_rom(0);
    push_exp(16'd1, 16'd5);
    send(16'd8, "mr_pre");
    wait_ready();
    din = 16'd8;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_busy", busy, 1);
    chk("mr_in_ready", in_ready, 0);
    rst = 1'b0;
    wait_clear();
    push_exp(16'd1, 16'd5);
    send(16'd8, "mr_post0");
    push_exp(16'd2, 16'd6);
    send(16'd0, "mr_post1");

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
